// File: rtl/conversor_bcd_a_binario_seq_pkg.sv
// Shared types and defaults for the sequential BCD-to-binary converter.
// Optional digit validation is enabled with the BCD_VALIDACION_EN macro.
package conversor_bcd_a_binario_seq_pkg;

    localparam int BUS_DAT     = 8;
    localparam int NUM_DIG_BCD = 3;

    typedef enum logic [1:0] {
        EST_IDLE = 2'd0,
        EST_CONV = 2'd1,
        EST_DONE = 2'd2
    } estado_e;

    function automatic logic digito_invalido(input logic [3:0] digito);
        return digito > 4'd9;
    endfunction

endpackage

// File: rtl/conversor_bcd_a_binario_seq_corrector.sv
// Per-digit correction cell of the reverse double-dabble: digits of 8 or more
// lose 3, undoing the carry that the right shift brought in from the digit above.
module conversor_bcd_a_binario_seq_corrector (
    input  logic [3:0] dig_in,
    output logic [3:0] dig_out
);

    assign dig_out = (dig_in >= 4'd8) ? (dig_in - 4'd3) : dig_in;

endmodule

// File: rtl/conversor_bcd_a_binario_seq.sv
// Sequential BCD-to-binary converter, one shift per clock, start/busy/done handshake.
// Define BCD_VALIDACION_EN to flag digits above 9 instead of converting them raw.
module conversor_bcd_a_binario_seq
    import conversor_bcd_a_binario_seq_pkg::*;
#(
    parameter int TAM_REG_BIN = BUS_DAT,
    parameter int NUM_DIG     = NUM_DIG_BCD
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inicio,
    input  logic [4*NUM_DIG-1:0]   reg_BCD,
    output logic                   ocupado,
    output logic                   listo,
    output logic [TAM_REG_BIN-1:0] reg_binario,
    output logic                   desborde,
    output logic                   error_bcd
);

    localparam int ANCHO_ACC = 4 * NUM_DIG;
    localparam int ANCHO_CNT = $clog2(ANCHO_ACC + 1);
    localparam logic [ANCHO_CNT-1:0] CNT_ULT = ANCHO_CNT'(ANCHO_ACC - 1);

    estado_e                estado_q, estado_d;
    logic [ANCHO_CNT-1:0]   cnt_q, cnt_d;
    logic [ANCHO_ACC-1:0]   bcd_q, bcd_d;
    logic [ANCHO_ACC-1:0]   bin_q, bin_d;
    logic                   err_q, err_d;
    logic                   ocupado_q, ocupado_d;
    logic                   listo_q, listo_d;
    logic [TAM_REG_BIN-1:0] binario_q, binario_d;
    logic                   desborde_q, desborde_d;
    logic                   error_bcd_q, error_bcd_d;

    logic [2*ANCHO_ACC-1:0] desplazado;
    logic [ANCHO_ACC-1:0]   bcd_sh, bin_sh, bcd_corr;
    logic [NUM_DIG-1:0]     dig_inval;
    logic [TAM_REG_BIN-1:0] acc_trunc;
    logic                   acc_over;

    // The BCD LSB falls into the MSB of the binary half on every shift.
    assign desplazado = {bcd_q, bin_q} >> 1;
    assign bcd_sh     = desplazado[2*ANCHO_ACC-1:ANCHO_ACC];
    assign bin_sh     = desplazado[ANCHO_ACC-1:0];

    for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_dig
        conversor_bcd_a_binario_seq_corrector u_corr (
            .dig_in  (bcd_sh[4*gi +: 4]),
            .dig_out (bcd_corr[4*gi +: 4])
        );
`ifdef BCD_VALIDACION_EN
        assign dig_inval[gi] = digito_invalido(reg_BCD[4*gi +: 4]);
`else
        assign dig_inval[gi] = 1'b0;
`endif
    end

    if (TAM_REG_BIN < ANCHO_ACC) begin : g_trunc
        assign acc_trunc = bin_sh[TAM_REG_BIN-1:0];
        assign acc_over  = |bin_sh[ANCHO_ACC-1:TAM_REG_BIN];
    end else begin : g_ext
        assign acc_trunc = TAM_REG_BIN'(bin_sh);
        assign acc_over  = 1'b0;
    end

    always_comb begin
        estado_d    = estado_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        bin_d       = bin_q;
        err_d       = err_q;
        binario_d   = binario_q;
        desborde_d  = desborde_q;
        error_bcd_d = error_bcd_q;
        case (estado_q)
            EST_IDLE: begin
                if (inicio) begin
                    estado_d = EST_CONV;
                    bcd_d    = reg_BCD;
                    bin_d    = '0;
                    cnt_d    = '0;
                    err_d    = |dig_inval;
                end
            end
            EST_CONV: begin
                bcd_d = bcd_corr;
                bin_d = bin_sh;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_ULT) begin
                    estado_d    = EST_DONE;
                    error_bcd_d = err_q;
                    binario_d   = err_q ? '0 : acc_trunc;
                    desborde_d  = err_q ? 1'b0 : acc_over;
                end
            end
            EST_DONE: estado_d = EST_IDLE;
            default:  estado_d = EST_IDLE;
        endcase
        // Handshake outputs are registered copies of the current state.
        ocupado_d = (estado_q == EST_CONV);
        listo_d   = (estado_q == EST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q    <= EST_IDLE;
            cnt_q       <= '0;
            bcd_q       <= '0;
            bin_q       <= '0;
            err_q       <= 1'b0;
            ocupado_q   <= 1'b0;
            listo_q     <= 1'b0;
            binario_q   <= '0;
            desborde_q  <= 1'b0;
            error_bcd_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            bin_q       <= bin_d;
            err_q       <= err_d;
            ocupado_q   <= ocupado_d;
            listo_q     <= listo_d;
            binario_q   <= binario_d;
            desborde_q  <= desborde_d;
            error_bcd_q <= error_bcd_d;
        end
    end

    assign ocupado     = ocupado_q;
    assign listo       = listo_q;
    assign reg_binario = binario_q;
    assign desborde    = desborde_q;
    assign error_bcd   = error_bcd_q;

endmodule

// File: tb/tb_conversor_bcd_a_binario_seq.sv
// Scoreboard bench for the BCD-to-binary converter: the driver queues expected
// results at each accepted start, a negedge monitor pops them on every listo.
module tb_conversor_bcd_a_binario_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inicio;
    logic [11:0] reg_BCD;
    logic        ocupado;
    logic        listo;
    logic [7:0]  reg_binario;
    logic        desborde;
    logic        error_bcd;

    typedef struct {
        logic [7:0] bin;
        logic       desb;
        logic       err;
        bit         lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   ocup_cnt = 0;
    int   n_listo = 0;
    int   last_listo_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    conversor_bcd_a_binario_seq #(.TAM_REG_BIN(8), .NUM_DIG(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inicio      (inicio),
        .reg_BCD     (reg_BCD),
        .ocupado     (ocupado),
        .listo       (listo),
        .reg_binario (reg_binario),
        .desborde    (desborde),
        .error_bcd   (error_bcd)
    );

    task automatic chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Monitor: every listo pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ocupado) ocup_cnt = ocup_cnt + 1;
        if (listo) begin
            n_listo = n_listo + 1;
            last_listo_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_listo", 1, 0);
            end else begin
                e = exp_q.pop_front();
                $display("listo: reg_binario=0x%02h desborde=%0b error_bcd=%0b (expect 0x%02h %0b %0b)",
                         reg_binario, desborde, error_bcd, e.bin, e.desb, e.err);
                chk("reg_binario", int'(reg_binario), int'(e.bin));
                chk("desborde", int'(desborde), int'(e.desb));
                chk("error_bcd", int'(error_bcd), int'(e.err));
                if (e.lat) begin
                    chk("latency_edges", cyc - start_cyc, 13);
                    chk("ocupado_cycles", ocup_cnt, 12);
                end
            end
        end
    end

    task automatic start_conv(input logic [11:0] bcd, input logic [7:0] eb,
                              input logic ed, input logic ee);
        @(negedge clk);
        reg_BCD = bcd;
        inicio  = 1'b1;
        exp_q.push_back('{bin: eb, desb: ed, err: ee, lat: 1'b1});
        @(posedge clk);
        #1;
        start_cyc = cyc;
        ocup_cnt  = 0;
        inicio    = 1'b0;
    endtask

    task automatic wait_listo(input int target);
        int n;
        n = 0;
        while (n_listo < target && n < 60) begin
            @(negedge clk);
            n = n + 1;
        end
        #1;
        if (n_listo < target) chk("listo_timeout", n_listo, target);
    endtask

    task automatic conv(input logic [11:0] bcd, input logic [7:0] eb,
                        input logic ed, input logic ee);
        int t;
        t = n_listo + 1;
        start_conv(bcd, eb, ed, ee);
        wait_listo(t);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ocupado"}, int'(ocupado), 0);
        chk({tag, "_listo"}, int'(listo), 0);
        chk({tag, "_reg_binario"}, int'(reg_binario), 0);
        chk({tag, "_desborde"}, int'(desborde), 0);
        chk({tag, "_error_bcd"}, int'(error_bcd), 0);
    endtask

    initial begin
        int t;
        int first_cyc;
        rst_n   = 1'b0;
        inicio  = 1'b0;
        reg_BCD = 12'h000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        // Directed conversions
        conv(12'h255, 8'hFF, 1'b0, 1'b0);
        conv(12'h000, 8'h00, 1'b0, 1'b0);
        conv(12'h001, 8'h01, 1'b0, 1'b0);
        conv(12'h100, 8'h64, 1'b0, 1'b0);
        conv(12'h999, 8'hE7, 1'b1, 1'b0);

        // inicio and reg_BCD changes during CONV are ignored
        t = n_listo + 1;
        start_conv(12'h128, 8'h80, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        reg_BCD = 12'h042;
        inicio  = 1'b1;
        @(negedge clk);
        inicio  = 1'b0;
        wait_listo(t);
        repeat (20) @(negedge clk);
        chk("single_listo", n_listo, t);

        // Reset in the middle of a conversion aborts it
        t = n_listo;
        start_conv(12'h255, 8'hFF, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk_outputs_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_listo", n_listo, t);
        conv(12'h042, 8'h2A, 1'b0, 1'b0);

        // Invalid digit: flagged with validation, raw weights (305) otherwise
`ifdef BCD_VALIDACION_EN
        conv(12'h2A5, 8'h00, 1'b0, 1'b1);
`else
        conv(12'h2A5, 8'h31, 1'b1, 1'b0);
`endif
        conv(12'h025, 8'h19, 1'b0, 1'b0);

        // inicio held high: back-to-back conversions, 14 cycles apart
        t = n_listo;
        @(negedge clk);
        reg_BCD = 12'h001;
        inicio  = 1'b1;
        exp_q.push_back('{bin: 8'h01, desb: 1'b0, err: 1'b0, lat: 1'b0});
        exp_q.push_back('{bin: 8'h01, desb: 1'b0, err: 1'b0, lat: 1'b0});
        wait_listo(t + 1);
        first_cyc = last_listo_cyc;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        wait_listo(t + 2);
        chk("throughput_cycles", last_listo_cyc - first_cyc, 14);

        repeat (5) @(negedge clk);
        chk("pending_expectations", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
